// File: rtl/token_collector_pkg.sv
// Shared constants, FSM state type and slot-pointer helper for the token collector.
package token_collector_pkg;

  localparam int NUM_TOKENS = 7;
  localparam int VAL_W      = 4;
  localparam int SLOT_W     = 3;

  typedef enum logic {
    SEEK = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Advance a slot index by one, wrapping from the last slot back to slot 0.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    if (s == SLOT_W'(NUM_TOKENS - 1)) begin
      return '0;
    end
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/token_collector_if.sv
// Slot-write and served-token handshake bundle between dispenser, collector and consumer.
import token_collector_pkg::*;

interface token_collector_if;

  logic [NUM_TOKENS-1:0]       tok_wr;
  logic [NUM_TOKENS*VAL_W-1:0] tok_data;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [VAL_W-1:0]            out_value;
  logic [SLOT_W-1:0]           out_slot;
  logic [SLOT_W-1:0]           occ_count;
  logic                        err_overwrite;

  // Environment side: deposits tokens, flushes and consumes served tokens.
  modport master (
    output tok_wr, tok_data, flush, out_ready,
    input  out_valid, out_value, out_slot, occ_count, err_overwrite
  );

  // Collector side.
  modport slave (
    input  tok_wr, tok_data, flush, out_ready,
    output out_valid, out_value, out_slot, occ_count, err_overwrite
  );

endinterface

// File: rtl/token_collector_slot.sv
// One token slot: value register plus occupied flag.
// A write is taken when the slot is empty or is being drained in the same cycle;
// a write to a slot that stays occupied is dropped and flagged as an overwrite.
import token_collector_pkg::*;

module token_slot (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             set,
  input  logic             clr,
  input  logic [VAL_W-1:0] data,
  output logic             occupied,
  output logic [VAL_W-1:0] value,
  output logic             accepted,
  output logic             overwrite
);

  assign accepted  = set & (~occupied | clr);
  assign overwrite = set & occupied & ~clr;

  // Slot storage: clear on reset/flush, refill wins over drain in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied <= 1'b0;
      value    <= '0;
    end else if (flush) begin
      occupied <= 1'b0;
      value    <= '0;
    end else if (accepted) begin
      occupied <= 1'b1;
      value    <= data;
    end else if (clr) begin
      occupied <= 1'b0;
    end
  end

endmodule

// File: rtl/token_collector.sv
// Token collector: gathers values written into numbered slots and serves them
// one at a time on a valid/ready output in slot order with wrap.
// Optional build macro TOKEN_COLLECTOR_SKIP_EN: while seeking, the pointer jumps
// in one cycle to the next occupied slot instead of waiting at the current one.
import token_collector_pkg::*;

module token_collector (
  input  logic              clk,
  input  logic              reset,
  token_collector_if.slave  bus
);

  state_t              state_reg;
  logic [SLOT_W-1:0]   ptr_reg;
  logic                valid_reg;
  logic [VAL_W-1:0]    value_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic [SLOT_W-1:0]   count_reg;
  logic [SLOT_W-1:0]   count_next;
  logic                err_reg;

  logic [NUM_TOKENS-1:0] occ;
  logic [NUM_TOKENS-1:0] won;
  logic [NUM_TOKENS-1:0] ovw;
  logic [NUM_TOKENS-1:0] clr;
  logic [VAL_W-1:0]      val [NUM_TOKENS];
  logic                  accept;
  int                    count_sum;

  assign accept = (state_reg == HOLD) && bus.out_ready;

  generate
    for (genvar gi = 0; gi < NUM_TOKENS; gi++) begin : g_slot
      assign clr[gi] = accept && (ptr_reg == SLOT_W'(gi));

      token_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .set       (bus.tok_wr[gi]),
        .clr       (clr[gi]),
        .data      (bus.tok_data[gi*VAL_W +: VAL_W]),
        .occupied  (occ[gi]),
        .value     (val[gi]),
        .accepted  (won[gi]),
        .overwrite (ovw[gi])
      );
    end
  endgenerate

  // Occupancy: old count minus the accepted token plus successful writes, clamped to range.
  always_comb begin
    count_sum = int'(count_reg);
    for (int i = 0; i < NUM_TOKENS; i++) begin
      count_sum = count_sum + int'(won[i]);
    end
    if (accept && count_sum > 0) begin
      count_sum = count_sum - 1;
    end
    if (count_sum > NUM_TOKENS) begin
      count_sum = NUM_TOKENS;
    end
    count_next = SLOT_W'(count_sum);
  end

`ifdef TOKEN_COLLECTOR_SKIP_EN
  logic              skip_found;
  logic [SLOT_W-1:0] skip_ptr;
  logic [SLOT_W-1:0] skip_idx;

  // Nearest occupied slot at or after ptr (with wrap); scanned far-to-near so the nearest wins.
  always_comb begin
    skip_found = 1'b0;
    skip_ptr   = ptr_reg;
    skip_idx   = '0;
    for (int k = NUM_TOKENS - 1; k >= 0; k--) begin
      skip_idx = SLOT_W'((int'(ptr_reg) + k) % NUM_TOKENS);
      if (occ[skip_idx]) begin
        skip_found = 1'b1;
        skip_ptr   = skip_idx;
      end
    end
  end
`endif

  // Serving FSM with registered outputs, occupancy counter and sticky overwrite flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= SEEK;
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      value_reg <= '0;
      slot_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (bus.flush) begin
      state_reg <= SEEK;
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      value_reg <= '0;
      slot_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (|ovw) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        SEEK: begin
          if (occ[ptr_reg]) begin
            valid_reg <= 1'b1;
            value_reg <= val[ptr_reg];
            slot_reg  <= ptr_reg;
            state_reg <= HOLD;
          end
`ifdef TOKEN_COLLECTOR_SKIP_EN
          else if (skip_found) begin
            ptr_reg <= skip_ptr;
          end
`endif
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            ptr_reg   <= slot_inc(ptr_reg);
            state_reg <= SEEK;
          end
        end
        default: state_reg <= SEEK;
      endcase
    end
  end

  assign bus.out_valid     = valid_reg;
  assign bus.out_value     = value_reg;
  assign bus.out_slot      = slot_reg;
  assign bus.occ_count     = count_reg;
  assign bus.err_overwrite = err_reg;

endmodule

// File: tb/tb_token_collector.sv
// Directed bench for token_collector: a per-cycle vector table plus hand-written
// sequences for asynchronous reset, pointer wrap, same-cycle refill and skip/stall.
module tb_token_collector;
  import token_collector_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  token_collector_if bus_if();

  token_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [6:0]  wr;
    logic [27:0] data;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [3:0]  eval;
    logic [2:0]  eslot;
    logic [2:0]  eocc;
    logic        eerr;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] put(input int s, input logic [3:0] v);
    logic [27:0] d;
    d = '0;
    d[s*4 +: 4] = v;
    return d;
  endfunction

  function automatic vec_t mk(input logic [6:0] wr, input logic [27:0] data, input logic fl,
                              input logic rdy, input logic ev, input logic [3:0] eval,
                              input logic [2:0] eslot, input logic [2:0] eocc, input logic eerr);
    vec_t v;
    v.wr = wr; v.data = data; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.eval = eval; v.eslot = eslot; v.eocc = eocc; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive(input logic [6:0] wr, input logic [27:0] data, input logic fl, input logic rdy);
    bus_if.tok_wr    = wr;
    bus_if.tok_data  = data;
    bus_if.flush     = fl;
    bus_if.out_ready = rdy;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [3:0] eval,
                           input logic [2:0] eslot, input logic [2:0] eocc, input logic eerr);
    check({tag, ".valid"}, int'(bus_if.out_valid), int'(ev));
    check({tag, ".occ"}, int'(bus_if.occ_count), int'(eocc));
    check({tag, ".err"}, int'(bus_if.err_overwrite), int'(eerr));
    if (ev) begin
      check({tag, ".value"}, int'(bus_if.out_value), int'(eval));
      check({tag, ".slot"}, int'(bus_if.out_slot), int'(eslot));
    end
    $display("%0t %s valid=%0d value=%h slot=%0d occ=%0d err=%0d", $time, tag, bus_if.out_valid,
             bus_if.out_value, bus_if.out_slot, bus_if.occ_count, bus_if.err_overwrite);
  endtask

  // Waits up to max_cycles for out_valid; counts an expired bound as a failed check.
  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!bus_if.out_valid && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, ".wait_valid"}, int'(bus_if.out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;

    // Table: basic serve, held output under backpressure, in-order drain, overwrite error.
    vt[0]  = mk(7'h00, 28'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    vt[1]  = mk(7'h01, put(0, 4'hA), 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 3'd1, 1'b0);
    vt[2]  = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd0, 3'd1, 1'b0);
    vt[3]  = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    vt[4]  = mk(7'h00, 28'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    vt[5]  = mk(7'h07, put(0, 4'h3) | put(1, 4'h5) | put(2, 4'h9), 1'b0, 1'b0,
                1'b0, 4'h0, 3'd0, 3'd3, 1'b0);
    for (int i = 6; i <= 10; i++) begin
      vt[i] = mk(7'h00, 28'h0, 1'b0, 1'b0, 1'b1, 4'h3, 3'd0, 3'd3, 1'b0);
    end
    vt[11] = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 3'd2, 1'b0);
    vt[12] = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b1, 4'h5, 3'd1, 3'd2, 1'b0);
    vt[13] = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 3'd1, 1'b0);
    vt[14] = mk(7'h00, 28'h0, 1'b0, 1'b0, 1'b1, 4'h9, 3'd2, 3'd1, 1'b0);
    vt[15] = mk(7'h04, put(2, 4'hE), 1'b0, 1'b0, 1'b1, 4'h9, 3'd2, 3'd1, 1'b1);
    vt[16] = mk(7'h00, 28'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
    vt[17] = mk(7'h00, 28'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
    vt[18] = mk(7'h00, 28'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // Reset state
    reset = 1'b1;
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    step();
    check_out("reset", 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    check("reset.value", int'(bus_if.out_value), 0);
    check("reset.slot", int'(bus_if.out_slot), 0);
    reset = 1'b0;

    // Asynchronous reset while holding slot 1 (ptr = 1)
    drive(7'h03, put(0, 4'h1) | put(1, 4'h2), 1'b0, 1'b0);
    step();
    check_out("ar_fill", 1'b0, 4'h0, 3'd0, 3'd2, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("ar_hold0", 1'b1, 4'h1, 3'd0, 3'd2, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b1);
    step();
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("ar_hold1", 1'b1, 4'h2, 3'd1, 3'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("ar_async", 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    step();
    reset = 1'b0;
    drive(7'h01, put(0, 4'h6), 1'b0, 1'b0);
    step();
    check_out("ar_wr0", 1'b0, 4'h0, 3'd0, 3'd1, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("ar_ptr0", 1'b1, 4'h6, 3'd0, 3'd1, 1'b0);

    // Table-driven run
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].wr, vt[i].data, vt[i].fl, vt[i].rdy);
      step();
      check_out($sformatf("vec%0d", i), vt[i].ev, vt[i].eval, vt[i].eslot, vt[i].eocc, vt[i].eerr);
    end

    // Walk ptr up to 6, then wrap 6 -> 0 with a same-cycle drain and refill of slot 6
    for (int s = 0; s < 6; s++) begin
      drive(7'(1 << s), put(s, 4'(s + 1)), 1'b0, 1'b0);
      step();
      drive(7'h00, 28'h0, 1'b0, 1'b0);
      step();
      check_out($sformatf("walk%0d", s), 1'b1, 4'(s + 1), 3'(s), 3'd1, 1'b0);
      drive(7'h00, 28'h0, 1'b0, 1'b1);
      step();
      check("walk.drain", int'(bus_if.out_valid), 0);
    end
    drive(7'h41, put(6, 4'hC) | put(0, 4'hD), 1'b0, 1'b0);
    step();
    check_out("wrap_fill", 1'b0, 4'h0, 3'd0, 3'd2, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("wrap_s6", 1'b1, 4'hC, 3'd6, 3'd2, 1'b0);
    drive(7'h40, put(6, 4'hF), 1'b0, 1'b1);
    step();
    check_out("refill6", 1'b0, 4'h0, 3'd0, 3'd2, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("wrap_s0", 1'b1, 4'hD, 3'd0, 3'd2, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b1);
    step();
    check_out("after_s0", 1'b0, 4'h0, 3'd0, 3'd1, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
`ifdef TOKEN_COLLECTOR_SKIP_EN
    wait_valid("skip6", 3);
    check_out("skip6", 1'b1, 4'hF, 3'd6, 3'd1, 1'b0);
`else
    for (int i = 0; i < 4; i++) step();
    check_out("stall_ptr1", 1'b0, 4'h0, 3'd0, 3'd1, 1'b0);
`endif
    drive(7'h00, 28'h0, 1'b1, 1'b0);
    step();
    check_out("flush_a", 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // Only slot 3 filled with ptr at 0: stall or skip, then flush while holding
    drive(7'h08, put(3, 4'hB), 1'b0, 1'b0);
    step();
    drive(7'h00, 28'h0, 1'b0, 1'b0);
`ifdef TOKEN_COLLECTOR_SKIP_EN
    wait_valid("skip3", 3);
    check_out("skip3", 1'b1, 4'hB, 3'd3, 3'd1, 1'b0);
`else
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.out_valid) vcount++;
    end
    check("strict_wait.valid_cycles", vcount, 0);
    drive(7'h01, put(0, 4'h2), 1'b0, 1'b0);
    step();
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("strict_s0", 1'b1, 4'h2, 3'd0, 3'd2, 1'b0);
`endif
    drive(7'h00, 28'h0, 1'b1, 1'b0);
    step();
    check_out("flush_hold", 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    drive(7'h00, 28'h0, 1'b0, 1'b0);
    step();
    check_out("post_flush", 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
